// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - MicroUAZ 8x8 register file with Z/C flags and R7 return stack
module reg_bank #(
  parameter int STACK_DEPTH = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_WrEn,
  input  logic [2:0] i_WrAddr,
  input  logic [7:0] i_WrData,
  input  logic       i_FlagEn,
  input  logic       i_Carry,
  input  logic [2:0] i_AddrX,
  input  logic [2:0] i_AddrY,
  input  logic       i_Push,
  input  logic       i_Pop,
  output logic [7:0] o_RX,
  output logic [7:0] o_RY,
  output logic       o_Zero,
  output logic       o_Carry,
  output logic       o_StackEmpty,
  output logic       o_StackFull,
  output logic       o_StackErr
);

  localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SPW = $clog2(STACK_DEPTH) + 1;

  logic [7:0]     regs      [8];
  logic [7:0]     regs_nxt  [8];
  logic [7:0]     stack_mem [STACK_DEPTH];
  logic [SPW-1:0] sp;
  logic [SPW-1:0] sp_nxt;
  logic [IW-1:0]  push_idx;
  logic [IW-1:0]  top_idx;
  logic           push_req;
  logic           pop_req;
  logic           push_ok;
  logic           pop_ok;
  logic           stack_err_set;

  assign o_StackEmpty = (sp == '0);
  assign o_StackFull  = (sp == SPW'(STACK_DEPTH));

  // Simultaneous push and pop cancel each other and never flag an error.
  assign push_req      = i_Push & ~i_Pop;
  assign pop_req       = i_Pop & ~i_Push;
  assign push_ok       = push_req & ~o_StackFull;
  assign pop_ok        = pop_req & ~o_StackEmpty;
  assign stack_err_set = (push_req & o_StackFull) | (pop_req & o_StackEmpty);

  assign push_idx = sp[IW-1:0];
  assign top_idx  = IW'(sp - SPW'(1));

  // Post-edge register image; read ports sample this so same-cycle writes forward.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      regs_nxt[i] = regs[i];
    end
    if (i_WrEn) begin
      regs_nxt[i_WrAddr] = i_WrData;
    end
    if (pop_ok) begin
      regs_nxt[7] = stack_mem[top_idx];
    end
    sp_nxt = sp;
    if (push_ok) begin
      sp_nxt = sp + SPW'(1);
    end else if (pop_ok) begin
      sp_nxt = sp - SPW'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= 8'h00;
      end
      o_RX       <= 8'h00;
      o_RY       <= 8'h00;
      o_Zero     <= 1'b0;
      o_Carry    <= 1'b0;
      sp         <= '0;
      o_StackErr <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= regs_nxt[i];
      end
      o_RX <= regs_nxt[i_AddrX];
      o_RY <= regs_nxt[i_AddrY];
      if (i_WrEn && i_FlagEn) begin
        o_Zero  <= (i_WrData == 8'h00);
        o_Carry <= i_Carry;
      end
      sp <= sp_nxt;
      if (stack_err_set) begin
        o_StackErr <= 1'b1;
      end
    end
  end

  // Stack storage needs no reset; the pushed value is the pre-write R7.
  always_ff @(posedge i_Clk) begin
    if (push_ok) begin
      stack_mem[push_idx] <= regs[7];
    end
  end

endmodule
